// File: rtl/gf180mcu_osu_sc_clkdiv_pkg.sv
// Shared types and helpers for the 12T programmable clock divider.
package gf180mcu_osu_sc_clkdiv_pkg;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_RESET_DIV = 2;

  // Ratio encoding to divide ratio (N = DIV + 2); one extra bit so all-ones never wraps.
  function automatic logic [16:0] div2n(input logic [15:0] div);
    return {1'b0, div} + 17'd2;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_ctr.sv
// Period counter with registered Y / TICK decode for the clock divider.
// nact is the ratio in force for the count produced by the current edge;
// restart forces the count back to 0, hold parks it at its current value.
module gf180mcu_osu_sc_12t_clkdiv_ctr #(
  parameter int            NW      = 5,
  parameter logic [NW-1:0] RESET_N = 5'd4
) (
  input  logic          clk,
  input  logic          rn,
  input  logic [NW-1:0] nact,
  input  logic          restart,
  input  logic          hold,
  output logic [NW-1:0] cnt,
  output logic          y,
  output logic          tick
);

  logic [NW-1:0] cnt_next;
  logic [NW-1:0] half;
  logic [NW-1:0] last_idx;

  // Next count and the duty/terminal thresholds for the ratio in force.
  always_comb begin
    cnt_next = cnt + NW'(1);
    if (restart) begin
      cnt_next = '0;
    end else if (hold) begin
      cnt_next = cnt;
    end
    half     = (nact + NW'(1)) >> 1;
    last_idx = nact - NW'(1);
  end

  // Count register plus registered outputs; a parked divider drives Y and TICK low.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      cnt  <= RESET_N - NW'(1);
      y    <= 1'b0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      y    <= !hold && (cnt_next < half);
      tick <= !hold && (cnt_next == last_idx);
    end
  end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_clkdiv.sv
// Programmable integer clock divider driving the 12T clock-buffer tree.
// Ratio changes use a level/ack handshake and only take effect on a period
// boundary, so Y never produces a runt pulse.
// Optional feature macro: CLKDIV_RUN_EN adds an EN input that parks the
// divider at the end of its current period while EN=0.
module gf180mcu_osu_sc_12t_clkdiv
  import gf180mcu_osu_sc_clkdiv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic             CLK,
  input  logic             RN,
`ifdef CLKDIV_RUN_EN
  input  logic             EN,
`endif
  input  logic [WIDTH-1:0] DIV,
  input  logic             LD,
  output logic             ACK,
  output logic             Y,
  output logic             TICK
);

  localparam int            NW      = WIDTH + 1;
  localparam logic [NW-1:0] RESET_N = NW'(RESET_DIV + 2);

  state_t           state;
  logic [NW-1:0]    nact;
  logic [NW-1:0]    nact_next;
  logic [NW-1:0]    cnt;
  logic [WIDTH-1:0] npend;
  logic             run;
  logic             last;
  logic             restart;
  logic             hold;

`ifdef CLKDIV_RUN_EN
  assign run = EN;
`else
  assign run = 1'b1;
`endif

  function automatic logic [NW-1:0] ratio(input logic [WIDTH-1:0] d);
    return NW'(div2n(16'(d)));
  endfunction

  // Boundary detection and selection of the ratio for the next period.
  always_comb begin
    last      = (cnt == nact - NW'(1));
    restart   = last && run;
    hold      = last && !run;
    nact_next = nact;
    if (restart) begin
      if (LD) begin
        nact_next = ratio(DIV);
      end else if (state == WAIT) begin
        nact_next = ratio(npend);
      end
    end
  end

  // Load handshake: queue requests mid-period, apply them at the boundary.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= RUN;
      nact  <= RESET_N;
      npend <= '0;
      ACK   <= 1'b0;
    end else begin
      nact <= nact_next;
      ACK  <= restart && (LD || (state == WAIT));
      case (state)
        RUN: begin
          if (!restart && LD) begin
            npend <= DIV;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (restart) begin
            state <= RUN;
          end else if (LD) begin
            npend <= DIV;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  gf180mcu_osu_sc_12t_clkdiv_ctr #(
    .NW      (NW),
    .RESET_N (RESET_N)
  ) u_ctr (
    .clk     (CLK),
    .rn      (RN),
    .nact    (nact_next),
    .restart (restart),
    .hold    (hold),
    .cnt     (cnt),
    .y       (Y),
    .tick    (TICK)
  );

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv.sv
// Self-checking bench for the 12T clock divider: directed scenarios plus
// random load traffic, compared against a period-level integer model.
module tb_gf180mcu_osu_sc_12t_clkdiv;

  localparam int W         = 4;
  localparam int RESET_DIV = 2;

  logic         CLK = 1'b0;
  logic         RN  = 1'b0;
  logic         en  = 1'b1;
  logic [W-1:0] DIV = '0;
  logic         LD  = 1'b0;
  logic         ACK;
  logic         Y;
  logic         TICK;

  int checks = 0;
  int errors = 0;

  // Model state: position within the current period, its length, queued encoding (-1 = none).
  int   m_pos;
  int   m_n;
  int   m_pend;
  logic e_y;
  logic e_tick;
  logic e_ack;

  gf180mcu_osu_sc_12t_clkdiv #(.WIDTH(W), .RESET_DIV(RESET_DIV)) dut (
    .CLK  (CLK),
    .RN   (RN),
`ifdef CLKDIV_RUN_EN
    .EN   (en),
`endif
    .DIV  (DIV),
    .LD   (LD),
    .ACK  (ACK),
    .Y    (Y),
    .TICK (TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b pos=%0d n=%0d", tag, obs, exp, m_pos, m_n);
    end
  endtask

  task automatic model_reset();
    m_n    = RESET_DIV + 2;
    m_pos  = m_n - 1;
    m_pend = -1;
    e_y    = 1'b0;
    e_tick = 1'b0;
    e_ack  = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input int div);
    if (m_pos == m_n - 1 && en) begin
      e_ack = ld || (m_pend >= 0);
      if (ld) m_n = div + 2;
      else if (m_pend >= 0) m_n = m_pend + 2;
      m_pend = -1;
      m_pos  = 0;
      e_y    = (m_pos < (m_n + 1) / 2);
      e_tick = (m_pos == m_n - 1);
    end else if (m_pos == m_n - 1) begin
      e_ack = 1'b0;
      if (ld) m_pend = div;
      e_y    = 1'b0;
      e_tick = 1'b0;
    end else begin
      e_ack = 1'b0;
      m_pos++;
      if (ld) m_pend = div;
      e_y    = (m_pos < (m_n + 1) / 2);
      e_tick = (m_pos == m_n - 1);
    end
  endtask

  task automatic step(input logic ld, input logic [W-1:0] div);
    LD  = ld;
    DIV = div;
    @(posedge CLK);
    model_edge(ld, int'(div));
    #1;
    chk("Y", Y, e_y);
    chk("TICK", TICK, e_tick);
    chk("ACK", ACK, e_ack);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 40 && m_pos != p; i++) step(1'b0, '0);
    checks++;
    assert (m_pos == p) else begin
      errors++;
      $error("FAIL wait_pos: observed=%0d expected=%0d", m_pos, p);
    end
  endtask

  initial begin
    model_reset();
    #12;
    chk("RST_Y", Y, 1'b0);
    chk("RST_TICK", TICK, 1'b0);
    chk("RST_ACK", ACK, 1'b0);
    #4 RN = 1'b1;
    #1;

    // Default ratio N=4 free-running.
    idle(12);

    // Request N=3 mid-period; applied at the next boundary.
    wait_pos(1);
    step(1'b1, 4'd1);
    idle(10);

    // Back to N=4, then two requests in one period: last writer wins.
    step(1'b1, 4'd2);
    idle(6);
    wait_pos(0);
    step(1'b1, 4'd3);
    step(1'b1, 4'd0);
    idle(8);

    // Maximum ratio loaded exactly on the boundary edge.
    wait_pos(m_n - 1);
    step(1'b1, 4'd15);
    idle(36);

    // Asynchronous reset with a pending request outstanding.
    wait_pos(1);
    step(1'b1, 4'd5);
    #2 RN = 1'b0;
    #1;
    chk("ARST_Y", Y, 1'b0);
    chk("ARST_TICK", TICK, 1'b0);
    chk("ARST_ACK", ACK, 1'b0);
    model_reset();
    #1 RN = 1'b1;
    idle(12);

    // Reloading the active ratio still acknowledges.
    wait_pos(2);
    step(1'b1, 4'd2);
    idle(6);

`ifdef CLKDIV_RUN_EN
    // Park at end of period, queue a ratio while parked, restart.
    wait_pos(1);
    en = 1'b0;
    idle(6);
    step(1'b1, 4'd1);
    idle(2);
    en = 1'b1;
    idle(8);
`endif

    // Random load traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 6) == 0, W'($urandom % 16));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
